// File: rtl/snake_step_if.sv
// Signal bundle between the snake step sequencer and its neighbours (keypad decoder,
// move block, body-segment streamer, draw block).
interface snake_step_if #(
    parameter int H = 5,
    parameter int V = 5
);
    // Handshake semantics: there is no ready anywhere on this bus. step and eat are
    // one-cycle strobes the consumer must take in the cycle they are high. seg_req is a
    // level asking the streamer to send body segments. Each seg_vld strobe carries exactly
    // one segment (seg_x/seg_y), and seg_last marks the final one. The sequencer always
    // accepts a strobe while seg_req is high and ignores strobes otherwise.
    logic         start;
    logic         pause;
    logic [3:0]   key_way;
    logic [H-1:0] head_x;
    logic [V-1:0] head_y;
    logic [H-1:0] food_x;
    logic [V-1:0] food_y;
    logic         seg_vld;
    logic [H-1:0] seg_x;
    logic [V-1:0] seg_y;
    logic         seg_last;
    logic         step;
    logic [3:0]   way;
    logic         seg_req;
    logic [9:0]   length;
    logic         eat;
    logic         game_over;
    logic         busy;

    modport slave (
        input  start, pause, key_way, head_x, head_y, food_x, food_y,
               seg_vld, seg_x, seg_y, seg_last,
        output step, way, seg_req, length, eat, game_over, busy
    );

    modport master (
        output start, pause, key_way, head_x, head_y, food_x, food_y,
               seg_vld, seg_x, seg_y, seg_last,
        input  step, way, seg_req, length, eat, game_over, busy
    );
endinterface

// File: rtl/snake_step_ctrl.sv
// Game-step sequencer: divides clk into step ticks, latches direction, pulses step,
// scans the body stream for self-collision and decides eat/grow or game over.
module snake_step_ctrl #(
    parameter logic [24:0] TICK_DIV      = 25'd12_500_000,
    parameter int          H_LOGIC_WIDTH = 5,
    parameter int          V_LOGIC_WIDTH = 5,
    parameter logic [9:0]  LEN_INIT      = 10'd3,
    parameter logic [9:0]  LEN_MAX       = 10'd200,
    parameter logic [9:0]  SCAN_TIMEOUT  = 10'd1023
) (
    input  logic         clk,
    input  logic         DLY_RST,
    snake_step_if.slave  bus,
    output logic [2:0]   dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STEP = 3'd2,
        S_SCAN = 3'd3,
        S_DONE = 3'd4,
        S_OVER = 3'd5
    } state_t;

    localparam logic [3:0] WAY_RIGHT = 4'b1000;

    state_t      state_q, state_d;
    logic [24:0] tick_cnt_q, tick_cnt_d;
    logic [9:0]  scan_cnt_q, scan_cnt_d;
    logic [3:0]  way_q, way_d;
    logic [3:0]  pending_q, pending_d;
    logic [9:0]  length_q, length_d;
    logic        step_q, step_d;
    logic        seg_req_q, seg_req_d;
    logic        eat_q, eat_d;
    logic        game_over_q, game_over_d;
    logic        busy_q, busy_d;
    logic        hit_q, hit_d;

    logic        key_onehot;
    logic [3:0]  way_opposite;
    logic        key_ok;
    logic        seg_match;
    logic        head_on_food;

    // Swapping R<->L and U<->D gives the reversal of the committed direction.
    assign way_opposite = {way_q[2], way_q[3], way_q[0], way_q[1]};
    assign key_onehot   = (bus.key_way != 4'b0000) &&
                          ((bus.key_way & (bus.key_way - 4'd1)) == 4'b0000);
    assign key_ok       = key_onehot && (bus.key_way != way_opposite);
    assign seg_match    = (bus.seg_x == bus.head_x) && (bus.seg_y == bus.head_y);
    assign head_on_food = (bus.head_x == bus.food_x) && (bus.head_y == bus.food_y);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        scan_cnt_d  = scan_cnt_q;
        way_d       = way_q;
        pending_d   = pending_q;
        length_d    = length_q;
        game_over_d = game_over_q;
        hit_d       = hit_q;
        eat_d       = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    tick_cnt_d  = 25'd0;
                    way_d       = WAY_RIGHT;
                    pending_d   = WAY_RIGHT;
                    length_d    = LEN_INIT;
                    game_over_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!bus.pause) begin
                    if (tick_cnt_q == TICK_DIV - 25'd1) begin
                        tick_cnt_d = 25'd0;
                        way_d      = pending_q;
                        state_d    = S_STEP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 25'd1;
                    end
                end
            end
            S_STEP: begin
                hit_d      = 1'b0;
                scan_cnt_d = 10'd0;
                state_d    = S_SCAN;
            end
            S_SCAN: begin
                if (bus.seg_vld && seg_match) begin
                    hit_d = 1'b1;
                end
                if ((bus.seg_vld && bus.seg_last) || (scan_cnt_q == SCAN_TIMEOUT - 10'd1)) begin
                    state_d = S_DONE;
                end else begin
                    scan_cnt_d = scan_cnt_q + 10'd1;
                end
            end
            S_DONE: begin
                tick_cnt_d = 25'd0;
                if (hit_q) begin
                    state_d     = S_OVER;
                    game_over_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                    if (head_on_food) begin
                        eat_d    = 1'b1;
                        length_d = (length_q >= LEN_MAX) ? LEN_MAX : length_q + 10'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reversal is judged against the committed way, so two quick presses cannot U-turn.
        if ((state_q == S_RUN || state_q == S_STEP || state_q == S_SCAN || state_q == S_DONE)
            && key_ok) begin
            pending_d = bus.key_way;
        end

        step_d    = (state_d == S_STEP);
        seg_req_d = (state_d == S_SCAN);
        busy_d    = (state_d == S_STEP) || (state_d == S_SCAN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (DLY_RST) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= 25'd0;
            scan_cnt_q  <= 10'd0;
            way_q       <= WAY_RIGHT;
            pending_q   <= WAY_RIGHT;
            length_q    <= LEN_INIT;
            step_q      <= 1'b0;
            seg_req_q   <= 1'b0;
            eat_q       <= 1'b0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            way_q       <= way_d;
            pending_q   <= pending_d;
            length_q    <= length_d;
            step_q      <= step_d;
            seg_req_q   <= seg_req_d;
            eat_q       <= eat_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
            hit_q       <= hit_d;
        end
    end

    assign bus.step      = step_q;
    assign bus.way       = way_q;
    assign bus.seg_req   = seg_req_q;
    assign bus.length    = length_q;
    assign bus.eat       = eat_q;
    assign bus.game_over = game_over_q;
    assign bus.busy      = busy_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Directed bench for snake_step_ctrl with small sim parameters (tick 4, length 3..5, scan timeout 8).
module tb_snake_step_ctrl;

  logic       clk;
  logic       DLY_RST;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected committed direction at each successive step pulse.
  logic [3:0] exp_q[$];

  snake_step_if #(.H(5), .V(5)) bus ();

  snake_step_ctrl #(
    .TICK_DIV      (25'd4),
    .H_LOGIC_WIDTH (5),
    .V_LOGIC_WIDTH (5),
    .LEN_INIT      (10'd3),
    .LEN_MAX       (10'd5),
    .SCAN_TIMEOUT  (10'd8)
  ) dut (
    .clk         (clk),
    .DLY_RST     (DLY_RST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_seg(input logic [4:0] x, input logic [4:0] y, input logic last);
    bus.seg_vld  = 1'b1;
    bus.seg_x    = x;
    bus.seg_y    = y;
    bus.seg_last = last;
    tick();
    bus.seg_vld  = 1'b0;
    bus.seg_last = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for the step pulse; returns the number of edges it took.
  task automatic run_to_step(output int n);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (bus.step) break;
    end
    check_eq("step_seen", {31'd0, bus.step}, 32'd1);
    check_eq("step_way", {28'd0, bus.way}, {28'd0, exp_q.pop_front()});
  endtask

  task automatic clean_round(input logic [4:0] hx, input logic [4:0] hy);
    bus.head_x = hx;
    bus.head_y = hy;
    tick();
    send_seg(5'd1, 5'd1, 1'b0);
    send_seg(5'd2, 5'd2, 1'b0);
    send_seg(5'd3, 5'd3, 1'b1);
    tick();
  endtask

  initial begin
    int n;
    int bad;

    exp_q = '{4'b1000, 4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b1000, 4'b0010};

    DLY_RST      = 1'b1;
    bus.start    = 1'b0;
    bus.pause    = 1'b0;
    bus.key_way  = 4'b0000;
    bus.head_x   = 5'd10;
    bus.head_y   = 5'd10;
    bus.food_x   = 5'd7;
    bus.food_y   = 5'd9;
    bus.seg_vld  = 1'b0;
    bus.seg_x    = 5'd0;
    bus.seg_y    = 5'd0;
    bus.seg_last = 1'b0;
    tick();
    tick();
    DLY_RST = 1'b0;

    check_eq("rst_state", {29'd0, dbg_state}, 32'd0);
    check_eq("rst_way", {28'd0, bus.way}, 32'h8);
    check_eq("rst_length", {22'd0, bus.length}, 32'd3);
    check_eq("rst_outs", {27'd0, bus.step, bus.seg_req, bus.eat, bus.game_over, bus.busy}, 32'd0);

    // Round 1: first step after 4 RUN cycles, reversal key ignored, no eat.
    pulse_start();
    check_eq("start_state", {29'd0, dbg_state}, 32'd1);
    bus.key_way = 4'b0100;
    run_to_step(n);
    check_eq("first_step_cycles", n, 32'd4);
    check_eq("step_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check_eq("step_one_cycle", {31'd0, bus.step}, 32'd0);
    check_eq("seg_req_up", {31'd0, bus.seg_req}, 32'd1);
    send_seg(5'd1, 5'd1, 1'b0);
    send_seg(5'd2, 5'd2, 1'b0);
    send_seg(5'd3, 5'd3, 1'b1);
    check_eq("done_state", {29'd0, dbg_state}, 32'd4);
    check_eq("done_seg_req", {31'd0, bus.seg_req}, 32'd0);
    check_eq("done_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check_eq("r1_eat", {31'd0, bus.eat}, 32'd0);
    check_eq("r1_length", {22'd0, bus.length}, 32'd3);
    check_eq("r1_run", {29'd0, dbg_state}, 32'd1);

    // Round 2: UP accepted; head on food -> eat, grow to 4.
    bus.key_way = 4'b0010;
    run_to_step(n);
    check_eq("tick_period", n, 32'd4);
    bus.key_way = 4'b0011;
    clean_round(5'd7, 5'd9);
    check_eq("r2_eat", {31'd0, bus.eat}, 32'd1);
    check_eq("r2_length", {22'd0, bus.length}, 32'd4);
    tick();
    check_eq("r2_eat_pulse", {31'd0, bus.eat}, 32'd0);

    // Round 3: committed UP; RIGHT then DOWN in one tick -> RIGHT.
    bus.key_way = 4'b1000;
    tick();
    bus.key_way = 4'b0001;
    run_to_step(n);
    bus.key_way = 4'b0000;
    clean_round(5'd7, 5'd9);
    check_eq("r3_length", {22'd0, bus.length}, 32'd5);

    // Round 4: length saturates at 5 while eat still pulses.
    run_to_step(n);
    clean_round(5'd7, 5'd9);
    check_eq("r4_eat", {31'd0, bus.eat}, 32'd1);
    check_eq("r4_length_sat", {22'd0, bus.length}, 32'd5);

    // Round 5: segment 2 hits the head while head is also on food -> game over wins.
    bus.key_way = 4'b0010;
    run_to_step(n);
    bus.key_way = 4'b0000;
    tick();
    send_seg(5'd1, 5'd1, 1'b0);
    send_seg(5'd7, 5'd9, 1'b0);
    send_seg(5'd3, 5'd3, 1'b1);
    tick();
    check_eq("over_flag", {31'd0, bus.game_over}, 32'd1);
    check_eq("over_no_eat", {31'd0, bus.eat}, 32'd0);
    check_eq("over_state", {29'd0, dbg_state}, 32'd5);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.step || bus.seg_req || !bus.game_over) bad++;
    end
    check_eq("over_hold", bad, 32'd0);
    pulse_start();
    check_eq("restart_over", {31'd0, bus.game_over}, 32'd0);
    check_eq("restart_length", {22'd0, bus.length}, 32'd3);
    check_eq("restart_way", {28'd0, bus.way}, 32'h8);
    check_eq("restart_state", {29'd0, dbg_state}, 32'd1);

    // Round 6: pause freezes the tick count; stray seg_vld in RUN is ignored; scan timeout.
    bus.head_x = 5'd4;
    bus.head_y = 5'd4;
    tick();
    tick();
    bus.pause = 1'b1;
    send_seg(5'd4, 5'd4, 1'b1);
    bad = 0;
    if (bus.step) bad++;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (bus.step) bad++;
    end
    check_eq("pause_no_step", bad, 32'd0);
    check_eq("pause_state", {29'd0, dbg_state}, 32'd1);
    bus.pause = 1'b0;
    run_to_step(n);
    check_eq("pause_remaining", n, 32'd2);
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.seg_req) break;
      n++;
      tick();
    end
    check_eq("scan_timeout_cycles", n, 32'd8);
    check_eq("timeout_done", {29'd0, dbg_state}, 32'd4);
    tick();
    check_eq("timeout_no_over", {31'd0, bus.game_over}, 32'd0);
    check_eq("timeout_no_eat", {31'd0, bus.eat}, 32'd0);
    check_eq("timeout_run", {29'd0, dbg_state}, 32'd1);

    // Round 7: reset in the middle of a scan.
    bus.key_way = 4'b0010;
    run_to_step(n);
    bus.key_way = 4'b0000;
    tick();
    send_seg(5'd1, 5'd1, 1'b0);
    DLY_RST = 1'b1;
    tick();
    check_eq("midrst_seg_req", {31'd0, bus.seg_req}, 32'd0);
    check_eq("midrst_state", {29'd0, dbg_state}, 32'd0);
    check_eq("midrst_way", {28'd0, bus.way}, 32'h8);
    check_eq("midrst_length", {22'd0, bus.length}, 32'd3);
    check_eq("midrst_outs", {28'd0, bus.step, bus.eat, bus.game_over, bus.busy}, 32'd0);
    DLY_RST = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
